approx_mult_seq: RTL and testbench
==================================

Name: approx_mult_seq

Overview:
- Parametrised, multi-cycle successor to the fixed 8x8 nibble-decomposed approximate multiplier.
- Splits WIDTH-bit unsigned operands into 4-bit chunks and forms one 4x4 partial product per cycle. Each partial product is shifted and accumulated into a 2*WIDTH result.
- Partial products of low significance can be approximated (low nibble dropped) under a per-operation mode bit.
- Sits between operand producer and consumer with valid/ready handshakes on both sides.

Parameters:
- WIDTH, 8, operand width in bits; must be a multiple of 4 and at least 8.
- APPROX_LVL, 1, in approximate mode, partial product pp(i,j) is approximated when i+j < APPROX_LVL; range 0..2*(WIDTH/4)-1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand request valid.
- in_ready  out  1  block can accept an operand pair.
- A  in  WIDTH  multiplicand, unsigned.
- B  in  WIDTH  multiplier, unsigned.
- approx_en  in  1  1 = approximate mode, 0 = exact; sampled with A/B.
- out_valid  out  1  R holds a completed product.
- out_ready  in  1  consumer accepts R.
- R  out  2*WIDTH  product.
- busy  out  1  high while partial products are being accumulated.

Behaviour:
- Reset values (async, immediate): state IDLE, in_ready=1, out_valid=0, busy=0, R=0, cycle counter=0, operand and mode registers=0.
- Chunk count: N = WIDTH/4. Total partial products K = N*N.
- Chunks: a_i = A[4i+3:4i] and b_j = B[4j+3:4j].
- Partial product: pp(i,j) = a_i*b_j, 8 bits, exact.
- Approximation: if the latched approx_en=1 and i+j < APPROX_LVL, pp(i,j)[3:0] is forced to 0 before accumulation.
- Accumulation: each pp(i,j) is shifted left by 4*(i+j) and added into a 2*WIDTH accumulator. The exact sum never overflows 2*WIDTH bits.
- Counter order: k = 0..K-1, with i = k mod N and j = k div N.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid=1: latch A, B, approx_en; clear the accumulator; clear the counter; go to BUSY.
- BUSY:
  - in_ready=0, busy=1.
  - Each cycle adds pp(k) and increments k.
  - After the cycle that adds k=K-1, load R with the final sum, set out_valid=1, and go to DONE.
- DONE:
  - out_valid=1; R is held stable.
  - in_ready=0. No new operation is accepted until the result is taken.
  - On out_ready=1: out_valid drops at the same edge and the FSM returns to IDLE.
- Latency: out_valid is first high after K rising edges following the accepting edge (K=4 for WIDTH=8; K=16 for WIDTH=16).
- Throughput: one operation per K+2 cycles (accept, K accumulate, handshake).
- Input changes while BUSY or DONE are ignored, because operands and mode are latched.
- out_ready while not in DONE has no effect.
- in_valid and out_ready both high in DONE: the result is handed over; the new operand is not accepted in that cycle because in_ready=0. It is accepted from IDLE on the next cycle.
- R keeps its last value after handover until the next completion.
- Reset asserted mid-operation: the operation is aborted immediately, all outputs take their reset values, and no partial result is ever presented.
- APPROX_LVL=0, or approx_en=0: R equals A*B exactly.

Test Plan:
- Exact mode, WIDTH=8: A=0xC7, B=0x96, approx_en=0 -> out_valid 4 edges after accept; R=29850 (0x749A).
- Approximate mode, WIDTH=8, APPROX_LVL=1: A=0xC7, B=0x96, approx_en=1 -> pp(0,0)=0x2A becomes 0x20; R=29840 (0x7490).
- Backpressure: hold out_ready=0 for 10 cycles after completion -> out_valid and R stay stable; in_ready=0 and a new in_valid is ignored. Raise out_ready -> one-cycle handover, in_ready=1 next cycle.
- Boundary values, WIDTH=16, exact mode: A=B=0xFFFF -> R=0xFFFE0001 after 16 edges. A=0 with any B -> R=0. Back-to-back operations give correct independent results.
- Reset mid-operation: assert rst during BUSY (k=2) -> out_valid=0, R=0, in_ready=1 immediately. Release rst, apply A=3, B=5 -> R=15 and no stale data.
- Random sweep, WIDTH=8, APPROX_LVL in {0,1,2}, both modes: compare R against a reference model built from the pp-zeroing rule -> zero mismatches.

Source files
------------

// File: rtl/approx_mult_seq_if.sv
// ---------------------------------------------------------------------------
// approx_mult_seq_if
// Operand/result handshake bundle for approx_mult_seq.
//   in_valid  : producer has an operand pair on A/B/approx_en
//   in_ready  : multiplier can accept an operand pair
//   A, B      : WIDTH-bit unsigned operands
//   approx_en : 1 = approximate low-significance partial products
//   out_valid : R holds a completed product
//   out_ready : consumer takes R
//   R         : 2*WIDTH-bit product
//   busy      : partial products are being accumulated
// master = producer/consumer side, slave = multiplier side.
// ---------------------------------------------------------------------------
interface approx_mult_seq_if #(
  parameter int WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     A;
  logic [WIDTH-1:0]     B;
  logic                 approx_en;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   R;
  logic                 busy;

  modport master (
    output in_valid, A, B, approx_en, out_ready,
    input  in_ready, out_valid, R, busy
  );

  modport slave (
    input  in_valid, A, B, approx_en, out_ready,
    output in_ready, out_valid, R, busy
  );
endinterface

// File: rtl/approx_mult_seq.sv
// ---------------------------------------------------------------------------
// approx_mult_seq
// Sequential nibble-decomposed approximate multiplier. Operands are split
// into 4-bit chunks; one 4x4 partial product is formed and accumulated per
// cycle (K = (WIDTH/4)^2 cycles). In approximate mode the low nibble of
// pp(i,j) is dropped when i+j < APPROX_LVL.
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : approx_mult_seq_if.slave (in/out valid-ready handshakes, A, B,
//         approx_en, R, busy)
// ---------------------------------------------------------------------------
module approx_mult_seq #(
  parameter int WIDTH      = 8,
  parameter int APPROX_LVL = 1
) (
  input  logic              clk,
  input  logic              rst,
  approx_mult_seq_if.slave  bus
);

  localparam int N     = WIDTH / 4;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int SUM_W = IDX_W + 1;
  localparam int RW    = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               mode_q, mode_d;
  logic [RW-1:0]      acc_q, acc_d;
  logic [RW-1:0]      r_q, r_d;
  logic [IDX_W-1:0]   i_q, i_d;
  logic [IDX_W-1:0]   j_q, j_d;

  logic [3:0]         a_nib, b_nib;
  logic [7:0]         pp_raw, pp;
  logic [SUM_W-1:0]   sig;
  logic [RW-1:0]      pp_ext;
  logic [RW-1:0]      sum;
  logic               last;

  // Drops the low nibble of a partial product whose significance i+j is
  // below the approximation threshold.
  function automatic logic [7:0] approx_pp(input logic [7:0]       p,
                                           input logic             mode,
                                           input logic [SUM_W-1:0] s);
    logic [7:0] res;
    res = p;
    if (mode && (int'(s) < APPROX_LVL)) begin
      res[3:0] = 4'h0;
    end
    return res;
  endfunction

  // Partial-product datapath: k = i + N*j, i is the fast index.
  assign a_nib  = a_q[{i_q, 2'b00} +: 4];
  assign b_nib  = b_q[{j_q, 2'b00} +: 4];
  assign pp_raw = {4'h0, a_nib} * {4'h0, b_nib};
  assign sig    = {1'b0, i_q} + {1'b0, j_q};
  assign pp     = approx_pp(pp_raw, mode_q, sig);
  assign pp_ext = {{(RW-8){1'b0}}, pp} << {sig, 2'b00};
  assign sum    = acc_q + pp_ext;
  assign last   = (i_q == IDX_W'(N-1)) && (j_q == IDX_W'(N-1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    mode_d  = mode_q;
    acc_d   = acc_q;
    r_d     = r_q;
    i_d     = i_q;
    j_d     = j_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.A;
          b_d     = bus.B;
          mode_d  = bus.approx_en;
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        acc_d = sum;
        if (last) begin
          r_d     = sum;
          state_d = DONE;
        end else if (i_q == IDX_W'(N-1)) begin
          i_d = '0;
          j_d = j_q + 1'b1;
        end else begin
          i_d = i_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register: everything resets so an aborted operation leaves no trace.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= 1'b0;
      acc_q   <= '0;
      r_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mode_q  <= mode_d;
      acc_q   <= acc_d;
      r_q     <= r_d;
      i_q     <= i_d;
      j_q     <= j_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q == BUSY);
  assign bus.out_valid = (state_q == DONE);
  assign bus.R         = r_q;

endmodule

// File: tb/tb_approx_mult_seq.sv
// ---------------------------------------------------------------------------
// tb_approx_mult_seq
// Bench for approx_mult_seq. Three WIDTH=8 instances (APPROX_LVL = 0, 1, 2,
// selected by index 0..2) and one WIDTH=16 instance (APPROX_LVL = 1, index 3)
// share operand buses; each has its own in_valid/out_ready.
// ---------------------------------------------------------------------------
module tb_approx_mult_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  logic [15:0] a_in = '0;
  logic [15:0] b_in = '0;
  logic        m_in = 1'b0;
  logic [3:0]  iv_a = '0;
  logic [3:0]  or_a = '0;
  wire  [3:0]  ir_a, ov_a, bz_a;
  wire  [31:0] r_a [4];

  for (genvar g = 0; g < 3; g++) begin : g8
    approx_mult_seq_if #(.WIDTH(8)) bus8 ();
    assign bus8.A         = a_in[7:0];
    assign bus8.B         = b_in[7:0];
    assign bus8.approx_en = m_in;
    assign bus8.in_valid  = iv_a[g];
    assign bus8.out_ready = or_a[g];
    assign ir_a[g]        = bus8.in_ready;
    assign ov_a[g]        = bus8.out_valid;
    assign bz_a[g]        = bus8.busy;
    assign r_a[g]         = {16'h0, bus8.R};
    approx_mult_seq #(.WIDTH(8), .APPROX_LVL(g)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus8)
    );
  end

  approx_mult_seq_if #(.WIDTH(16)) bus16 ();
  assign bus16.A         = a_in;
  assign bus16.B         = b_in;
  assign bus16.approx_en = m_in;
  assign bus16.in_valid  = iv_a[3];
  assign bus16.out_ready = or_a[3];
  assign ir_a[3]         = bus16.in_ready;
  assign ov_a[3]         = bus16.out_valid;
  assign bz_a[3]         = bus16.busy;
  assign r_a[3]          = bus16.R;

  approx_mult_seq #(.WIDTH(16), .APPROX_LVL(1)) u_dut16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16)
  );

  // Reference: sum of shifted nibble products with the low-nibble zeroing rule.
  function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b,
                                          input logic m, input int lvl, input int n);
    logic [31:0] acc;
    logic [7:0]  p;
    acc = '0;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < n; j++) begin
        p = 8'(a[4*i +: 4]) * 8'(b[4*j +: 4]);
        if (m && ((i + j) < lvl)) p[3:0] = 4'h0;
        acc = acc + (32'(p) << (4 * (i + j)));
      end
    end
    return acc;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Wait (bounded) for out_valid; returns edges counted since call.
  task automatic wait_done(input int sel, output int n);
    n = 0;
    while (ov_a[sel] !== 1'b1 && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  // One full operation: accept, check latency, pop expectation, hand over.
  task automatic op(input int sel, input logic [15:0] a, input logic [15:0] b,
                    input logic m, input logic [31:0] expv);
    int n;
    logic [31:0] e;
    chk("in_ready_before", 32'(ir_a[sel]), 32'd1);
    a_in = a; b_in = b; m_in = m;
    iv_a[sel] = 1'b1;
    exp_q.push_back(expv);
    @(posedge clk); #1;
    iv_a[sel] = 1'b0;
    chk("busy_after_accept", 32'(bz_a[sel]), 32'd1);
    chk("in_ready_busy", 32'(ir_a[sel]), 32'd0);
    wait_done(sel, n);
    chk("latency", 32'(n), (sel == 3) ? 32'd16 : 32'd4);
    e = exp_q.pop_front();
    chk("R", r_a[sel], e);
    or_a[sel] = 1'b1;
    @(posedge clk); #1;
    or_a[sel] = 1'b0;
    chk("out_valid_after_take", 32'(ov_a[sel]), 32'd0);
    chk("in_ready_after_take", 32'(ir_a[sel]), 32'd1);
    chk("R_held_after_take", r_a[sel], e);
  endtask

  initial begin
    int n;
    logic [15:0] ra, rb;
    logic        rm;
    logic [31:0] e;

    // Reset state while rst is held
    #12;
    for (int s = 0; s < 4; s++) begin
      chk("rst_in_ready", 32'(ir_a[s]), 32'd1);
      chk("rst_out_valid", 32'(ov_a[s]), 32'd0);
      chk("rst_busy", 32'(bz_a[s]), 32'd0);
      chk("rst_R", r_a[s], 32'd0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed WIDTH=8 cases on APPROX_LVL=1 instance
    op(1, 16'h00C7, 16'h0096, 1'b0, 32'd29850);
    op(1, 16'h00C7, 16'h0096, 1'b1, 32'd29840);
    op(0, 16'h00C7, 16'h0096, 1'b1, 32'd29850);
    op(2, 16'h00FF, 16'h00FF, 1'b0, 32'hFE01);

    // Backpressure: result held 10 cycles, new in_valid ignored meanwhile
    a_in = 16'h0055; b_in = 16'h0033; m_in = 1'b0;
    iv_a[1] = 1'b1;
    @(posedge clk); #1;
    wait_done(1, n);
    chk("bp_latency", 32'(n), 32'd4);
    a_in = 16'h00FF; b_in = 16'h00FF;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("bp_out_valid", 32'(ov_a[1]), 32'd1);
      chk("bp_in_ready", 32'(ir_a[1]), 32'd0);
      chk("bp_R", r_a[1], 32'd4335);
    end
    or_a[1] = 1'b1;
    @(posedge clk); #1;
    or_a[1] = 1'b0;
    chk("bp_handover_ov", 32'(ov_a[1]), 32'd0);
    chk("bp_handover_ir", 32'(ir_a[1]), 32'd1);
    chk("bp_handover_R", r_a[1], 32'd4335);
    exp_q.push_back(32'hFE01);
    @(posedge clk); #1;
    iv_a[1] = 1'b0;
    chk("bp_next_busy", 32'(bz_a[1]), 32'd1);
    wait_done(1, n);
    chk("bp_next_latency", 32'(n), 32'd4);
    e = exp_q.pop_front();
    chk("bp_next_R", r_a[1], e);
    or_a[1] = 1'b1;
    @(posedge clk); #1;
    or_a[1] = 1'b0;

    // WIDTH=16 boundaries and back-to-back
    op(3, 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001);
    op(3, 16'h0000, 16'hBEEF, 1'b0, 32'h0);
    op(3, 16'h1234, 16'hABCD, 1'b0, 32'(16'h1234) * 32'(16'hABCD));
    op(3, 16'h8001, 16'h7FFF, 1'b0, 32'(16'h8001) * 32'(16'h7FFF));
    op(3, 16'hFFFF, 16'hFFFF, 1'b1, ref_mul(16'hFFFF, 16'hFFFF, 1'b1, 1, 4));

    // Reset during BUSY at k=2
    a_in = 16'h1234; b_in = 16'h5678; m_in = 1'b0;
    iv_a[3] = 1'b1;
    @(posedge clk); #1;
    iv_a[3] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(ov_a[3]), 32'd0);
    chk("midrst_R", r_a[3], 32'd0);
    chk("midrst_in_ready", 32'(ir_a[3]), 32'd1);
    chk("midrst_busy", 32'(bz_a[3]), 32'd0);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    op(3, 16'd3, 16'd5, 1'b0, 32'd15);

    // Random sweep over the WIDTH=8 instances, both modes
    for (int t = 0; t < 36; t++) begin
      ra = 16'($urandom_range(0, 255));
      rb = 16'($urandom_range(0, 255));
      rm = 1'($urandom_range(0, 1));
      op(t % 3, ra, rb, rm, ref_mul(ra, rb, rm, t % 3, 2));
    end
    for (int t = 0; t < 4; t++) begin
      ra = 16'($urandom_range(0, 65535));
      rb = 16'($urandom_range(0, 65535));
      rm = 1'(t % 2);
      op(3, ra, rb, rm, ref_mul(ra, rb, rm, 1, 4));
    end

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
